// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully connected layer address generator.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ag_state_t;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/address_generator_if.sv
// Control-unit to address-generator bus. The control unit is the master;
// the address generator is the slave. Optional macro: AG_BIAS_EN adds is_bias.
interface address_generator_if #(
    parameter int IN_ADDR_W = 2,
    parameter int W_ADDR_W  = 5,
    parameter int NIDX_W    = 2
);
    logic                 AG_rst;
    logic                 AG_read;
    logic [IN_ADDR_W-1:0] in_addr;
    logic [W_ADDR_W-1:0]  w_addr;
    logic [NIDX_W-1:0]    neuron_idx;
    logic                 addr_valid;
    logic                 last_input;
    logic                 neuron_done;
    logic                 done;
`ifdef AG_BIAS_EN
    logic                 is_bias;
`endif

    modport master (
        output AG_rst, AG_read,
        input  in_addr, w_addr, neuron_idx, addr_valid, last_input, neuron_done, done
`ifdef AG_BIAS_EN
        , input is_bias
`endif
    );

    modport slave (
        input  AG_rst, AG_read,
        output in_addr, w_addr, neuron_idx, addr_valid, last_input, neuron_done, done
`ifdef AG_BIAS_EN
        , output is_bias
`endif
    );

endinterface

// File: rtl/address_generator_wrap_counter.sv
// Up-counter running 0..MAX that returns to zero on the enable after MAX.
// wrap flags that the counter currently sits on its terminal value.
module wrap_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: synchronous clear has priority over stepping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign wrap  = (count_q == W'(MAX));

endmodule

// File: rtl/address_generator.sv
// Input/weight address generator for the fully connected layer.
// Optional macro: AG_BIAS_EN appends a bias step to every neuron.
//
// state | meaning
// IDLE  | after reset, addresses not valid, AG_read ignored
// RUN   | stepping addresses on each AG_read
// DONE  | whole layer consumed, outputs frozen until AG_rst
module address_generator
    import nn_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 4,
    parameter int IN_ADDR_W = clog2_min1(N_INPUTS),
    parameter int W_ADDR_W  = $clog2(N_NEURONS * (N_INPUTS + 1))
) (
    input  logic                clk,
    input  logic                reset,
    address_generator_if.slave  ag
);

`ifdef AG_BIAS_EN
    localparam int STEPS = N_INPUTS + 1;
`else
    localparam int STEPS = N_INPUTS;
`endif
    localparam int STEP_W = clog2_min1(STEPS);
    localparam int NIDX_W = clog2_min1(N_NEURONS);

    ag_state_t           state_q, state_d;
    logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic                neuron_done_q, neuron_done_d;

    logic [STEP_W-1:0]   step_cnt;
    logic [NIDX_W-1:0]   neuron_cnt;
    logic                step_wrap;
    logic                neuron_wrap;
    logic                advance;
    logic                final_step;
    logic                step_en;
    logic                neuron_en;

    // Consume decode: restart beats a read, and the layer's final step
    // freezes every counter so addresses hold their last values in DONE.
    always_comb begin
        advance    = (state_q == RUN) && ag.AG_read && !ag.AG_rst;
        final_step = advance && step_wrap && neuron_wrap;
        step_en    = advance && !final_step;
        neuron_en  = advance && step_wrap && !final_step;
    end

    wrap_counter #(.MAX(STEPS - 1), .W(STEP_W)) u_step_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ag.AG_rst),
        .en    (step_en),
        .count (step_cnt),
        .wrap  (step_wrap)
    );

    wrap_counter #(.MAX(N_NEURONS - 1), .W(NIDX_W)) u_neuron_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ag.AG_rst),
        .en    (neuron_en),
        .count (neuron_cnt),
        .wrap  (neuron_wrap)
    );

    // Next state, running weight address and the per-neuron completion pulse.
    always_comb begin
        state_d       = state_q;
        w_addr_d      = w_addr_q;
        neuron_done_d = advance && step_wrap;
        if (ag.AG_rst) begin
            state_d  = RUN;
            w_addr_d = '0;
        end else if (final_step) begin
            state_d = DONE;
        end else if (advance) begin
            w_addr_d = w_addr_q + 1'b1;
        end
    end

    // Registered state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            w_addr_q      <= '0;
            neuron_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_addr_q      <= w_addr_d;
            neuron_done_q <= neuron_done_d;
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
`ifdef AG_BIAS_EN
        ag.in_addr = step_wrap ? IN_ADDR_W'(N_INPUTS - 1) : IN_ADDR_W'(step_cnt);
        ag.is_bias = (state_q == RUN) && step_wrap;
`else
        ag.in_addr = IN_ADDR_W'(step_cnt);
`endif
        ag.w_addr      = w_addr_q;
        ag.neuron_idx  = neuron_cnt;
        ag.addr_valid  = (state_q == RUN);
        ag.last_input  = (state_q == RUN) && step_wrap;
        ag.neuron_done = neuron_done_q;
        ag.done        = (state_q == DONE);
    end

endmodule
